// File: rtl/drac_pkg.sv
// Shared pipeline types for the ID -> IR boundary and instruction queue defaults.
package drac_pkg;

  localparam int unsigned XLEN             = 64;
  localparam int unsigned NUM_SCALAR_INSTR = 2;

  localparam int unsigned IQ_DEPTH = 8;
  localparam int unsigned IQ_W_IN  = 2;
  localparam int unsigned IQ_R_OUT = 2;
  localparam int unsigned IQ_PTR_W = $clog2(IQ_DEPTH);
  localparam int unsigned IQ_CNT_W = $clog2(IQ_DEPTH + 1);

  typedef logic [IQ_PTR_W-1:0] iq_ptr_t;
  typedef logic [IQ_CNT_W-1:0] iq_cnt_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     bits;
  } instr_entry_t;

  typedef struct packed {
    instr_entry_t instr;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
  } id_ir_stage_t;

endpackage

// File: rtl/iq_lane_compactor.sv
// Packs valid lanes toward index 0 preserving lane order and reports how many were valid.
module iq_lane_compactor
  import drac_pkg::*;
#(
  parameter int unsigned W_IN = 2
) (
  input  id_ir_stage_t [W_IN-1:0]          lanes,
  output id_ir_stage_t [W_IN-1:0]          packed_lanes,
  output logic [$clog2(W_IN+1)-1:0]        count
);

  localparam int unsigned IDX_W = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int unsigned CNT_W = $clog2(W_IN + 1);

  always_comb begin
    int unsigned idx;
    packed_lanes = '0;
    idx          = 0;
    for (int k = 0; k < W_IN; k++) begin
      if (lanes[k].instr.valid) begin
        packed_lanes[IDX_W'(idx)] = lanes[k];
        idx = idx + 1;
      end
    end
    count = CNT_W'(idx);
  end

endmodule

// File: rtl/instruction_queue_mw.sv
// Multi-width in-order instruction queue between ID and IR: all-or-nothing
// enqueue of compacted lanes, variable-count dequeue, first-word-fall-through head.
module instruction_queue_mw
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned W_IN  = IQ_W_IN,
  parameter int unsigned R_OUT = IQ_R_OUT
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            flush_i,
  input  id_ir_stage_t [W_IN-1:0]         instr_i,
  output logic                            enq_ready_o,
  input  logic [$clog2(R_OUT+1)-1:0]      deq_cnt_i,
  output id_ir_stage_t [R_OUT-1:0]        instr_o,
  output logic [R_OUT-1:0]                head_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]      free_cnt_o,
  output logic                            full_o,
  output logic                            empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DEQ_W = $clog2(R_OUT + 1);
  localparam int unsigned NIN_W = $clog2(W_IN + 1);

  id_ir_stage_t            storage [DEPTH];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [CNT_W-1:0]        num;

  id_ir_stage_t [W_IN-1:0] packed_lanes;
  logic [NIN_W-1:0]        n_in;
  logic [CNT_W-1:0]        free_cnt;
  logic [CNT_W-1:0]        add_cnt;
  logic [CNT_W-1:0]        deq_eff;
  logic                    accept;

  iq_lane_compactor #(.W_IN(W_IN)) u_compactor (
    .lanes        (instr_i),
    .packed_lanes (packed_lanes),
    .count        (n_in)
  );

  // Admission uses registered free space only; slots freed this cycle are not reusable.
  always_comb begin
    free_cnt = CNT_W'(DEPTH) - num;
    accept   = (CNT_W'(n_in) <= free_cnt) && !flush_i;
    add_cnt  = accept ? CNT_W'(n_in) : '0;
    deq_eff  = (CNT_W'(deq_cnt_i) > num) ? num : CNT_W'(deq_cnt_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head <= '0;
      tail <= '0;
      num  <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
      num  <= '0;
    end else begin
      head <= head + PTR_W'(deq_eff);
      tail <= tail + PTR_W'(add_cnt);
      num  <= num + add_cnt - deq_eff;
    end
  end

  // Storage is data-only; validity is tracked by num, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int k = 0; k < W_IN; k++) begin
        if (NIN_W'(k) < n_in) begin
          storage[tail + PTR_W'(k)] <= packed_lanes[k];
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < R_OUT; j++) begin
      head_valid_o[j]          = (num > CNT_W'(j));
      instr_o[j]               = storage[head + PTR_W'(j)];
      instr_o[j].instr.valid   = head_valid_o[j];
    end
  end

  assign free_cnt_o  = free_cnt;
  assign full_o      = (num == CNT_W'(DEPTH));
  assign empty_o     = (num == '0);
  assign enq_ready_o = (free_cnt >= CNT_W'(W_IN));

  deq_le_num_a : assert property (@(posedge clk_i) disable iff (!rstn_i)
                                  (CNT_W'(deq_cnt_i) <= num));

  logic [DEQ_W-1:0] unused_deq_w;
  assign unused_deq_w = '0;

endmodule

// File: tb/tb_instruction_queue_mw.sv
// Directed self-checking bench for instruction_queue_mw at DEPTH=8, W_IN=2, R_OUT=2.
module tb_instruction_queue_mw;
  import drac_pkg::*;

  logic                    clk;
  logic                    rstn;
  logic                    flush;
  id_ir_stage_t [1:0]      instr_in;
  logic                    enq_ready;
  logic [1:0]              deq_cnt;
  id_ir_stage_t [1:0]      instr_out;
  logic [1:0]              head_valid;
  logic [3:0]              free_cnt;
  logic                    full;
  logic                    empty;

  int tests;
  int fails;

  instruction_queue_mw #(.DEPTH(8), .W_IN(2), .R_OUT(2)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .flush_i      (flush),
    .instr_i      (instr_in),
    .enq_ready_o  (enq_ready),
    .deq_cnt_i    (deq_cnt),
    .instr_o      (instr_out),
    .head_valid_o (head_valid),
    .free_cnt_o   (free_cnt),
    .full_o       (full),
    .empty_o      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic id_ir_stage_t mk(input logic v, input logic [63:0] pc);
    id_ir_stage_t e;
    e             = '0;
    e.instr.valid = v;
    e.instr.pc    = pc;
    e.instr.bits  = 32'h13 + pc[31:0];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected status values derived from the occupancy the bench is tracking.
  task automatic chk_status(input string tag, input int n);
    chk({tag, ".empty"},  64'(empty),      64'(n == 0));
    chk({tag, ".full"},   64'(full),       64'(n == 8));
    chk({tag, ".free"},   64'(free_cnt),   64'(8 - n));
    chk({tag, ".ready"},  64'(enq_ready),  64'((8 - n) >= 2));
    chk({tag, ".hv"},     64'(head_valid), 64'({n > 1, n > 0}));
    chk({tag, ".v0"},     64'(instr_out[0].instr.valid), 64'(n > 0));
    chk({tag, ".v1"},     64'(instr_out[1].instr.valid), 64'(n > 1));
  endtask

  task automatic drive(input logic v0, input logic [63:0] pc0,
                       input logic v1, input logic [63:0] pc1, input logic [1:0] d);
    instr_in[0] = mk(v0, pc0);
    instr_in[1] = mk(v1, pc1);
    deq_cnt     = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rstn     = 1'b0;
    flush    = 1'b0;
    instr_in = '0;
    deq_cnt  = '0;

    // 1: reset state, then async reset mid-stream
    step(); step();
    chk_status("rst", 0);
    rstn = 1'b1;
    step();
    drive(1, 64'h100, 1, 64'h104, 0); step();
    drive(1, 64'h108, 1, 64'h10c, 0); step();
    drive(1, 64'h110, 0, 64'h0,   0); step();
    chk_status("pre_rst5", 5);
    drive(0, 0, 0, 0, 0);
    rstn = 1'b0;
    #1;
    chk_status("mid_rst", 0);
    step();
    rstn = 1'b1;
    step();
    chk_status("post_rst", 0);

    // 2: fill with PC 0..7, then a rejected push
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'(2 * i), 1, 64'(2 * i + 1), 0);
      step();
      chk_status($sformatf("fill%0d", i), 2 * (i + 1));
    end
    chk("fill.pc0", instr_out[0].instr.pc, 64'h0);
    chk("fill.pc1", instr_out[1].instr.pc, 64'h1);
    drive(1, 64'h8, 1, 64'h9, 0); step();
    chk_status("rej", 8);
    chk("rej.pc0", instr_out[0].instr.pc, 64'h0);

    // 4: full + deq 2 + enq 2 rejects; refill, then drain across the wrap
    drive(1, 64'h20, 1, 64'h21, 2); step();
    chk_status("fulldeq", 6);
    chk("fulldeq.pc0", instr_out[0].instr.pc, 64'h2);
    drive(1, 64'h20, 1, 64'h21, 0); step();
    chk_status("refill", 8);
    begin
      logic [63:0] exp_pc [8];
      exp_pc = '{64'h2, 64'h3, 64'h4, 64'h5, 64'h6, 64'h7, 64'h20, 64'h21};
      for (int i = 0; i < 4; i++) begin
        drive(0, 0, 0, 0, 2);
        chk($sformatf("drain%0d.pc0", i), instr_out[0].instr.pc, exp_pc[2 * i]);
        chk($sformatf("drain%0d.pc1", i), instr_out[1].instr.pc, exp_pc[2 * i + 1]);
        step();
        chk_status($sformatf("drain%0d", i), 6 - 2 * i);
      end
    end

    // 3: only lane 1 valid, no same-cycle bypass
    drive(0, 64'h99, 1, 64'h40, 0);
    #1;
    chk_status("nobypass", 0);
    step();
    chk_status("lane1", 1);
    chk("lane1.pc0", instr_out[0].instr.pc, 64'h40);

    // 5: three entries, deq 1 with enqueue 2
    drive(1, 64'h41, 1, 64'h42, 0); step();
    chk_status("three", 3);
    drive(1, 64'h43, 1, 64'h44, 1); step();
    chk_status("deq1enq2", 4);
    chk("deq1enq2.pc0", instr_out[0].instr.pc, 64'h41);
    chk("deq1enq2.pc1", instr_out[1].instr.pc, 64'h42);

    // 6: flush with concurrent enqueue and dequeue
    drive(1, 64'h45, 0, 64'h0, 0); step();
    chk_status("five", 5);
    flush = 1'b1;
    drive(1, 64'h50, 1, 64'h51, 1); step();
    flush = 1'b0;
    chk_status("flush", 0);
    drive(1, 64'h60, 1, 64'h61, 0); step();
    chk_status("postflush", 2);
    chk("postflush.pc0", instr_out[0].instr.pc, 64'h60);
    chk("postflush.pc1", instr_out[1].instr.pc, 64'h61);
    drive(0, 0, 0, 0, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
